sum_result_serializer: RTL and testbench

//   Downstream stage of the quad serial adder. Captures the 64-bit sum and carry

---
 rtl/sum_result_serializer_if.sv | 29 ++
 rtl/sum_result_serializer.sv | 130 +++++++++++++
 tb/tb_sum_result_serializer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_result_serializer_if.sv
// Result handoff from the quad serial adder and the beat stream toward the sink.
// master drives done/result/carry/ready/clear; slave is the serializer side.
interface sum_result_serializer_if #(
    parameter int DATA_W = 64,
    parameter int OUT_W  = 8
);
    logic              done;
    logic [DATA_W-1:0] result;
    logic              carryOut;
    logic              out_ready;
    logic              clr_overrun;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              out_carry;
    logic              busy;
    logic              full;
    logic              overrun;

    modport master (
        output done, result, carryOut, out_ready, clr_overrun,
        input  out_valid, out_data, out_last, out_carry, busy, full, overrun
    );

    modport slave (
        input  done, result, carryOut, out_ready, clr_overrun,
        output out_valid, out_data, out_last, out_carry, busy, full, overrun
    );
endinterface

// File: rtl/sum_result_serializer.sv
// Captures adder sum+carry on a done rising edge and streams it LSB-first as OUT_W beats.
// 1-cycle latency from done edge; holds beats under backpressure, one pending slot, drops beyond.
module sum_result_serializer #(
    parameter int DATA_W = 64,
    parameter int OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sum_result_serializer_if.slave bus
);
    localparam int BEATS = DATA_W / OUT_W;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              carry_q, carry_d;
    logic              pend_carry_q, pend_carry_d;
    logic [KW-1:0]     k_q, k_d;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic              done_q;
    logic              cap, hs, last_hs, drop;

    assign cap     = bus.done & ~done_q;
    assign hs      = (state_q == SEND) & bus.out_ready;
    assign last_hs = hs & (k_q == K_LAST);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        carry_d      = carry_q;
        pend_carry_d = pend_carry_q;
        k_d          = k_q;
        full_d       = full_q;
        overrun_d    = overrun_q;
        drop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (cap) begin
                    state_d = SEND;
                    shift_d = bus.result;
                    carry_d = bus.carryOut;
                    k_d     = '0;
                end
            end
            SEND: begin
                if (last_hs) begin
                    // Stream ends: chain straight into the next result with no idle beat.
                    if (full_q) begin
                        shift_d = pend_q;
                        carry_d = pend_carry_q;
                        k_d     = '0;
                        if (cap) begin
                            pend_d       = bus.result;
                            pend_carry_d = bus.carryOut;
                        end else begin
                            full_d = 1'b0;
                        end
                    end else if (cap) begin
                        shift_d = bus.result;
                        carry_d = bus.carryOut;
                        k_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs) begin
                        shift_d = shift_q >> OUT_W;
                        k_d     = k_q + KW'(1);
                    end
                    if (cap) begin
                        if (!full_q) begin
                            pend_d       = bus.result;
                            pend_carry_d = bus.carryOut;
                            full_d       = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh drop outranks a clear landing in the same cycle.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            pend_q       <= '0;
            carry_q      <= 1'b0;
            pend_carry_q <= 1'b0;
            k_q          <= '0;
            full_q       <= 1'b0;
            overrun_q    <= 1'b0;
            done_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            carry_q      <= carry_d;
            pend_carry_q <= pend_carry_d;
            k_q          <= k_d;
            full_q       <= full_d;
            overrun_q    <= overrun_d;
            done_q       <= bus.done;
        end
    end

    assign bus.out_valid = (state_q == SEND);
    assign bus.busy      = (state_q == SEND);
    assign bus.out_data  = shift_q[OUT_W-1:0];
    assign bus.out_last  = (state_q == SEND) & (k_q == K_LAST);
    assign bus.out_carry = carry_q;
    assign bus.full      = full_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sum_result_serializer.sv
// Bench for sum_result_serializer: directed scenarios plus random traffic against a queue model.
module tb_sum_result_serializer;
    localparam int DATA_W = 64;
    localparam int OUT_W  = 8;
    localparam int BEATS  = DATA_W / OUT_W;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              c;
    } res_t;

    logic clk;
    logic rst;
    sum_result_serializer_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    sum_result_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Model: queue of accepted results (head is streaming, second is pending).
    res_t mq[$];
    int   mb    = 0;
    logic mov   = 1'b0;
    logic mprev = 1'b1;

    logic [9:0] log_q[$];

    always @(posedge clk) begin
        logic mcap;
        logic mdrop;
        res_t r;
        if (rst) begin
            mq.delete();
            mb    = 0;
            mov   = 1'b0;
            mprev = 1'b1;
        end else begin
            mcap  = bus.done && !mprev;
            mprev = bus.done;
            mdrop = 1'b0;
            if (mq.size() > 0 && bus.out_ready) begin
                mb++;
                if (mb == BEATS) begin
                    void'(mq.pop_front());
                    mb = 0;
                end
            end
            if (mcap) begin
                if (mq.size() < 2) begin
                    r.d = bus.result;
                    r.c = bus.carryOut;
                    mq.push_back(r);
                end else begin
                    mdrop = 1'b1;
                end
            end
            if (mdrop) mov = 1'b1;
            else if (bus.clr_overrun) mov = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [DATA_W-1:0] d;
        logic              v;
        v = (mq.size() > 0);
        chk("out_valid", bus.out_valid, v);
        chk("busy", bus.busy, v);
        chk("full", bus.full, mq.size() == 2);
        chk("overrun", bus.overrun, mov);
        if (v) begin
            d = mq[0].d;
            chk("out_data", bus.out_data, d[mb*OUT_W +: OUT_W]);
            chk("out_last", bus.out_last, mb == BEATS - 1);
            if (mb == BEATS - 1) chk("out_carry", bus.out_carry, mq[0].c);
        end else begin
            chk("out_last_idle", bus.out_last, 1'b0);
        end
    endtask

    task automatic tick();
        if (!rst && bus.out_valid && bus.out_ready)
            log_q.push_back({bus.out_carry, bus.out_last, bus.out_data});
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [DATA_W-1:0] d, input logic c);
        bus.result   = d;
        bus.carryOut = c;
        bus.done     = 1'b1;
    endtask

    // Literal check of 8 logged beats starting at off against the expected word.
    task automatic chk_stream(input int off, input logic [DATA_W-1:0] d, input logic c);
        logic [9:0] e;
        if (log_q.size() < off + BEATS) begin
            chk("stream_len", log_q.size(), off + BEATS);
            return;
        end
        for (int k = 0; k < BEATS; k++) begin
            e = log_q[off + k];
            chk("beat_data", e[7:0], d[k*OUT_W +: OUT_W]);
            chk("beat_last", e[8], k == BEATS - 1);
            if (k == BEATS - 1) chk("beat_carry", e[9], c);
        end
    endtask

    localparam logic [63:0] A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] B = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] C = 64'hDEAD_BEEF_0000_1111;
    localparam logic [63:0] D = 64'h1122_3344_5566_7788;

    initial begin
        rst             = 1'b1;
        bus.done        = 1'b0;
        bus.result      = '0;
        bus.carryOut    = 1'b0;
        bus.out_ready   = 1'b1;
        bus.clr_overrun = 1'b0;
        ticks(2);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 8'h00);
        chk("rst_carry", bus.out_carry, 1'b0);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_overrun", bus.overrun, 1'b0);
        rst = 1'b0;
        tick();

        // Single result
        log_q.delete();
        start(A, 1'b1);
        tick();
        chk("t1_first_valid", bus.out_valid, 1'b1);
        chk("t1_first_data", bus.out_data, 8'hEF);
        bus.done = 1'b0;
        ticks(8);
        chk("t1_idle_after", bus.out_valid, 1'b0);
        chk("t1_count", log_q.size(), 8);
        chk_stream(0, A, 1'b1);

        // Backpressure on beat 2
        log_q.delete();
        start(A, 1'b1);
        tick();
        bus.done = 1'b0;
        ticks(2);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_data", bus.out_data, 8'hAB);
            chk("t2_hold_valid", bus.out_valid, 1'b1);
        end
        bus.out_ready = 1'b1;
        ticks(6);
        chk("t2_count", log_q.size(), 8);
        chk_stream(0, A, 1'b1);
        tick();

        // Back-to-back with pending
        log_q.delete();
        start(A, 1'b1);
        tick();
        bus.done = 1'b0;
        ticks(3);
        start(B, 1'b0);
        tick();
        chk("t3_full", bus.full, 1'b1);
        bus.done = 1'b0;
        ticks(12);
        chk("t3_count_no_bubble", log_q.size(), 16);
        chk("t3_idle_after", bus.out_valid, 1'b0);
        chk_stream(0, A, 1'b1);
        chk_stream(8, B, 1'b0);

        // Overrun
        log_q.delete();
        start(A, 1'b1);
        tick();
        bus.done = 1'b0;
        ticks(2);
        start(B, 1'b0);
        tick();
        bus.done = 1'b0;
        tick();
        start(C, 1'b1);
        tick();
        chk("t4_overrun", bus.overrun, 1'b1);
        chk("t4_full", bus.full, 1'b1);
        bus.done = 1'b0;
        ticks(11);
        chk("t4_count", log_q.size(), 16);
        chk_stream(0, A, 1'b1);
        chk_stream(8, B, 1'b0);
        chk("t4_overrun_sticky", bus.overrun, 1'b1);
        bus.clr_overrun = 1'b1;
        tick();
        bus.clr_overrun = 1'b0;
        chk("t4_overrun_clr", bus.overrun, 1'b0);

        // Reset mid-stream with pending full, done held through reset
        start(A, 1'b1);
        tick();
        bus.done = 1'b0;
        ticks(2);
        start(B, 1'b0);
        ticks(2);
        rst = 1'b1;
        tick();
        chk("t5_valid", bus.out_valid, 1'b0);
        chk("t5_data", bus.out_data, 8'h00);
        chk("t5_last", bus.out_last, 1'b0);
        chk("t5_carry", bus.out_carry, 1'b0);
        chk("t5_full", bus.full, 1'b0);
        rst = 1'b0;
        tick();
        chk("t5_no_capture", bus.out_valid, 1'b0);
        bus.done = 1'b0;
        tick();

        // Done held high for 10 cycles
        log_q.delete();
        start(D, 1'b0);
        ticks(10);
        bus.done = 1'b0;
        ticks(2);
        chk("t6_count", log_q.size(), 8);
        chk_stream(0, D, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.out_ready   = ($urandom_range(0, 9) < 7);
            bus.clr_overrun = ($urandom_range(0, 49) == 0);
            rst             = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0) begin
                bus.done     = ~bus.done;
                bus.result   = {$urandom, $urandom};
                bus.carryOut = $urandom_range(0, 1) == 1;
            end
            tick();
        end
        rst             = 1'b0;
        bus.done        = 1'b0;
        bus.out_ready   = 1'b1;
        bus.clr_overrun = 1'b0;
        ticks(20);
        chk("drain_idle", bus.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
